demux1_4_stream: RTL and testbench

- 1-to-4 demultiplexer with per-output valid/ready handshakes; it is the distributing counterpart of the team's 4:1 2-bit mux.
- One WIDTH-bit input stream is steered by sel[1:0] into one of four single-entry output holding registers.
- Each output drains independently.
- Per-channel delivered-item counters are provided for debug and testbench checking.

---
 rtl/demux1_4_stream.sv | 108 ++++++++++
 tb/tb_demux1_4_stream.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/demux1_4_stream.sv
// demux1_4_stream: steers one valid/ready input stream into four independent
// single-entry output holding registers, selected per word by sel.
// Each channel keeps a wrapping count of the items it has delivered.

// One output channel: a single holding register plus its delivery counter.
module demux1_4_stream_chan #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next state: a drain empties the slot and counts; a load in the same
    // cycle refills it, so back-to-back items see no bubble.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
    end

    // State registers; reset discards any held item without counting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;
endmodule

module demux1_4_stream #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   d_in,
    input  logic [1:0]         sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   d0,
    output logic [WIDTH-1:0]   d1,
    output logic [WIDTH-1:0]   d2,
    output logic [WIDTH-1:0]   d3,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*CNT_W-1:0] cnt_out
);
    localparam int NUM_CH = 4;

    logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_load;
    logic                         accept;

    // Only the addressed channel gates acceptance, so a stalled channel never
    // blocks words bound elsewhere. in_valid is deliberately not involved.
    assign in_ready = !out_valid[sel] || out_ready[sel];
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_load[k] = accept && (sel == 2'(k));

        demux1_4_stream_chan #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .load_i  (ch_load[k]),
            .data_i  (d_in),
            .ready_i (out_ready[k]),
            .data_o  (ch_data[k]),
            .valid_o (out_valid[k]),
            .cnt_o   (cnt_out[k*CNT_W +: CNT_W])
        );
    end

    assign d0 = ch_data[0];
    assign d1 = ch_data[1];
    assign d2 = ch_data[2];
    assign d3 = ch_data[3];
endmodule

// File: tb/tb_demux1_4_stream.sv
// Bench for demux1_4_stream: directed scenarios plus random traffic, all
// compared against a per-channel slot/count model held in the bench.
module tb_demux1_4_stream;
    localparam int WIDTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] d_in;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [4*CNT_W-1:0] cnt_out;

    int n_cmp = 0;
    int n_err = 0;

    // Model: each channel is a slot that is either empty or holds one item,
    // its last-loaded value, and the number of items it has handed out.
    bit         m_full [4];
    logic [1:0] m_val  [4];
    int         m_sent [4];

    demux1_4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_out   (cnt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !m_full[sel] || out_ready[sel];
    endfunction

    function automatic logic [7:0] cnt_of(input int k);
        return cnt_out[k*CNT_W +: CNT_W];
    endfunction

    // One clock: check in_ready before the edge, advance the model at the
    // edge, then check all registered outputs on the falling edge.
    task automatic cycle();
        bit take;
        logic [3:0]  exp_v;
        logic [31:0] exp_c;
        #1;
        chk("in_ready", in_ready, m_ready());
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_full[k] = 0; m_val[k] = '0; m_sent[k] = 0;
            end
        end else begin
            take = in_valid && m_ready();
            for (int k = 0; k < 4; k++) begin
                if (m_full[k] && out_ready[k]) begin
                    m_sent[k]++;
                    m_full[k] = 0;
                end
                if (take && sel == 2'(k)) begin
                    m_full[k] = 1;
                    m_val[k]  = d_in;
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            exp_v[k] = m_full[k];
            exp_c[k*8 +: 8] = 8'(m_sent[k] % 256);
        end
        chk("out_valid", out_valid, exp_v);
        chk("d0", d0, m_val[0]);
        chk("d1", d1, m_val[1]);
        chk("d2", d2, m_val[2]);
        chk("d3", d3, m_val[3]);
        chk("cnt_out", cnt_out, exp_c);
    endtask

    task automatic drive(input bit r, input bit v, input logic [1:0] s,
                         input logic [1:0] d, input logic [3:0] ordy);
        rst = r; in_valid = v; sel = s; d_in = d; out_ready = ordy;
        cycle();
    endtask

    initial begin
        rst = 1; in_valid = 0; sel = 0; d_in = 0; out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 0; m_val[k] = '0; m_sent[k] = 0;
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 4'b0000);
        chk("rst_valid", out_valid, 4'b0000);
        chk("rst_cnt", cnt_out, 32'h0);
        chk("rst_d", {d3, d2, d1, d0}, 8'h00);

        // Stream one word to each channel with every consumer ready.
        drive(0, 1, 2'b00, 2'b01, 4'b1111);
        drive(0, 1, 2'b01, 2'b10, 4'b1111);
        chk("stream_d0", d0, 2'b01);
        drive(0, 1, 2'b10, 2'b11, 4'b1111);
        chk("stream_d1", d1, 2'b10);
        drive(0, 1, 2'b11, 2'b00, 4'b1111);
        chk("stream_d2", d2, 2'b11);
        drive(0, 0, 2'b00, 2'b00, 4'b1111);
        drive(0, 0, 2'b00, 2'b00, 4'b1111);
        chk("stream_cnt", cnt_out, 32'h01010101);

        // Back-pressure on channel 2 while channel 0 keeps flowing.
        drive(1, 0, 0, 0, 4'b0000);
        drive(0, 1, 2'b10, 2'b10, 4'b1011);
        chk("bp_first_v", out_valid[2], 1'b1);
        rst = 0; in_valid = 1; sel = 2'b10; d_in = 2'b01; out_ready = 4'b1011;
        #1 chk("bp_blocked", in_ready, 1'b0);
        cycle();
        chk("bp_hold_d2", d2, 2'b10);
        drive(0, 1, 2'b00, 2'b11, 4'b1011);
        chk("bp_other_d0", d0, 2'b11);
        chk("bp_other_d2", d2, 2'b10);
        rst = 0; in_valid = 1; sel = 2'b10; d_in = 2'b01; out_ready = 4'b1111;
        #1 chk("bp_release", in_ready, 1'b1);
        cycle();
        chk("bp_new_d2", d2, 2'b01);
        chk("bp_cnt2", cnt_of(2), 8'd1);

        // Same-cycle drain and load on channel 1.
        drive(1, 0, 0, 0, 4'b0000);
        drive(0, 1, 2'b01, 2'b01, 4'b0000);
        drive(0, 1, 2'b01, 2'b10, 4'b0010);
        chk("dl_valid1", out_valid[1], 1'b1);
        chk("dl_d1", d1, 2'b10);
        chk("dl_cnt1", cnt_of(1), 8'd1);

        // Reset with held items on channels 0, 1, 3.
        drive(0, 1, 2'b00, 2'b11, 4'b0000);
        drive(0, 1, 2'b11, 2'b01, 4'b0000);
        chk("pre_rst_v", out_valid, 4'b1011);
        drive(1, 0, 0, 0, 4'b0000);
        chk("mid_rst_v", out_valid, 4'b0000);
        chk("mid_rst_cnt", cnt_out, 32'h0);
        chk("mid_rst_d", {d3, d2, d1, d0}, 8'h00);
        #1 chk("mid_rst_rdy", in_ready, 1'b1);

        // 256 deliveries on channel 3 wrap its counter back to zero.
        for (int i = 0; i < 256; i++)
            drive(0, 1, 2'b11, 2'($urandom), 4'b1000);
        chk("wrap_255", cnt_of(3), 8'd255);
        drive(0, 0, 0, 0, 4'b1000);
        chk("wrap_0", cnt_of(3), 8'd0);
        chk("wrap_others", cnt_out[23:0], 24'h0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 99) == 0), 1'($urandom), 2'($urandom),
                  2'($urandom), 4'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
